// File: rtl/fetch_unit_if.sv
// Bundle of every signal between the fetch unit and its surroundings:
// PC register, instruction memory, decode and the execute redirect path.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A raised valid holds its payload stable until that transfer
// happens. Ready may depend on nothing but the receiver's own state.
// A redirect may withdraw an imem request before it is accepted; a redirect
// may also clear inst_valid before inst_ready arrives.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic [1:0]      dbg_state;

    // Fetch unit side.
    modport master (
        input  pc_in,
        output pc_next, pc_en,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready, redirect_valid, redirect_target,
        output dbg_state
    );

    // Environment side (PC register, memory, decode, execute).
    modport slave (
        output pc_in,
        input  pc_next, pc_en,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready, redirect_valid, redirect_target,
        input  dbg_state
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: one memory request in flight at a time, the
// fetched word is held for decode, execute redirects override everything.
module fetch_unit #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input logic        clk,
    input logic        rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            drop, drop_n;      // discard the next memory response
    logic [XLEN-1:0] req_pc;            // address of the request in flight
    logic [XLEN-1:0] inst_data_q, inst_pc_q;
    logic            inst_valid_q;

    logic            accept;
    logic            load_inst;
    logic            clr_inst;
    logic            req_valid;
    logic            pc_en;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] redir_pc;

    assign seq_pc   = bus.pc_in + XLEN'(PC_STEP);
    assign redir_pc = {bus.redirect_target[XLEN-1:2], 2'b00};

    // Next state, request/PC controls; a redirect overrides the PC update last.
    always_comb begin
        state_n   = state;
        drop_n    = drop;
        accept    = 1'b0;
        load_inst = 1'b0;
        clr_inst  = 1'b0;
        req_valid = 1'b0;
        pc_en     = 1'b0;
        pc_next   = seq_pc;
        case (state)
            FETCH: begin
                // A redirect withdraws the request unless memory takes it now.
                req_valid = !(bus.redirect_valid && !bus.imem_req_ready);
                accept    = req_valid && bus.imem_req_ready;
                if (accept) begin
                    state_n = WAIT;
                    pc_en   = 1'b1;
                    drop_n  = bus.redirect_valid;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (drop || bus.redirect_valid) begin
                        state_n = FETCH;
                        drop_n  = 1'b0;
                    end else begin
                        load_inst = 1'b1;
                        state_n   = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    drop_n = 1'b1;
                end
            end
            HOLD: begin
                if (bus.redirect_valid || bus.inst_ready) begin
                    clr_inst = 1'b1;
                    state_n  = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
        if (bus.redirect_valid) begin
            pc_en   = 1'b1;
            pc_next = redir_pc;
        end
        if (rst) begin
            req_valid = 1'b0;
            pc_en     = 1'b0;
        end
    end

    // State register and drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
        end
    end

    // Capture the PC of the request memory just accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc <= '0;
        end else if (accept) begin
            req_pc <= bus.pc_in;
        end
    end

    // Instruction output register towards decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else if (load_inst) begin
            inst_valid_q <= 1'b1;
            inst_data_q  <= bus.imem_rsp_data;
            inst_pc_q    <= req_pc;
        end else if (clr_inst) begin
            inst_valid_q <= 1'b0;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = bus.pc_in;
    assign bus.pc_en          = pc_en;
    assign bus.pc_next        = pc_next;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst_data      = inst_data_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.dbg_state      = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and instruction memory models around the
// DUT, directed scenarios plus a randomized run against a stream model.
module tb_fetch_unit;
    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_unit_if #(.XLEN(XLEN)) bus();

    fetch_unit #(.XLEN(XLEN), .PC_STEP(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register.
    logic            pc_load;
    logic [XLEN-1:0] pc_load_val;
    logic [XLEN-1:0] pc_reg;
    always @(posedge clk) begin
        if (pc_load) pc_reg <= pc_load_val;
        else if (bus.pc_en) pc_reg <= bus.pc_next;
    end
    assign bus.pc_in = pc_reg;

    // ---------------- memory model state ----------------
    logic            pend;
    int              cnt;
    logic [XLEN-1:0] paddr;
    int              mem_delay;
    logic            mem_rand;

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return a ^ 32'h0100_0013;
    endfunction

    // ---------------- scoreboard state ----------------
    logic [XLEN-1:0] exp_q[$];
    logic            sb_en;
    int              deliveries;
    logic            prev_req_hold, prev_inst_hold;
    logic [XLEN-1:0] prev_addr, prev_ipc, prev_idata;

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input logic [XLEN-1:0] base);
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        pend = 1'b0;
        cnt = 0;
        mem_delay = 1;
        mem_rand = 1'b0;
        prev_req_hold = 1'b0;
        prev_inst_hold = 1'b0;
        pc_load = 1'b1;
        pc_load_val = base;
        @(posedge clk); #1;
        pc_load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Finish the current cycle: stream checks, memory bookkeeping, next edge.
    task automatic adv();
        logic acc;
        logic [XLEN-1:0] tgt;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        if (sb_en) begin
            if (pend) begin
                checks++;
                if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL sb_one_outstanding got %b exp 0", bus.imem_req_valid); end
            end
            if (prev_req_hold && !bus.redirect_valid) begin
                checks++;
                if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== prev_addr) begin errors++; $display("FAIL sb_req_stable got %b/%h exp 1/%h", bus.imem_req_valid, bus.imem_req_addr, prev_addr); end
            end
            if (prev_inst_hold) begin
                checks++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== prev_ipc || bus.inst_data !== prev_idata) begin errors++; $display("FAIL sb_inst_stable got %b/%h/%h exp 1/%h/%h", bus.inst_valid, bus.inst_pc, bus.inst_data, prev_ipc, prev_idata); end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                checks++;
                if (bus.inst_pc !== exp_q[0] || bus.inst_data !== mem_word(exp_q[0])) begin errors++; $display("FAIL sb_stream got %h/%h exp %h/%h", bus.inst_pc, bus.inst_data, exp_q[0], mem_word(exp_q[0])); end
                deliveries++;
                tgt = exp_q.pop_front() + 32'd4;
                exp_q.push_back(tgt);
            end
            if (bus.redirect_valid) begin
                tgt = {bus.redirect_target[XLEN-1:2], 2'b00};
                checks++;
                if (bus.pc_en !== 1'b1 || bus.pc_next !== tgt) begin errors++; $display("FAIL sb_redirect_pc got %b/%h exp 1/%h", bus.pc_en, bus.pc_next, tgt); end
                exp_q.delete();
                exp_q.push_back(tgt);
            end else if (acc) begin
                checks++;
                if (bus.pc_en !== 1'b1 || bus.pc_next !== bus.pc_in + 32'd4 || bus.imem_req_addr !== bus.pc_in) begin errors++; $display("FAIL sb_accept_pc got %b/%h exp 1/%h", bus.pc_en, bus.pc_next, bus.pc_in + 32'd4); end
            end else begin
                checks++;
                if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL sb_pc_en_idle got %b exp 0", bus.pc_en); end
            end
        end
        prev_req_hold  = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
        prev_inst_hold = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
        prev_addr  = bus.imem_req_addr;
        prev_ipc   = bus.inst_pc;
        prev_idata = bus.inst_data;
        if (acc) begin
            pend  = 1'b1;
            cnt   = mem_rand ? int'($urandom_range(1, 3)) : mem_delay;
            paddr = bus.imem_req_addr;
        end
        @(posedge clk); #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data = mem_word(paddr);
                pend = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset(32'h0100_0000);
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", bus.imem_req_valid); end
        checks++; if (bus.pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en got %b exp 0", bus.pc_en); end
        checks++; if (bus.inst_valid !== 1'b0 || bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst got %b/%h/%h exp 0/0/0", bus.inst_valid, bus.inst_data, bus.inst_pc); end
        checks++; if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.dbg_state); end
        rst = 1'b0;
    endtask

    // Test plan items 1 and 3.
    task automatic test_basic_hold();
        apply_reset(32'h0100_0000);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0100_0000) begin errors++; $display("FAIL t1_req got %b/%h exp 1/01000000", bus.imem_req_valid, bus.imem_req_addr); end
        checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h0100_0004) begin errors++; $display("FAIL t1_pc got %b/%h exp 1/01000004", bus.pc_en, bus.pc_next); end
        adv();
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL t1_wait got %b/%b/%b exp 0/0/0", bus.inst_valid, bus.imem_req_valid, bus.pc_en); end
        adv();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0100_0000 || bus.inst_data !== 32'h0000_0013) begin errors++; $display("FAIL t3_hold%0d got %b/%h/%h exp 1/01000000/00000013", i, bus.inst_valid, bus.inst_pc, bus.inst_data); end
            checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL t3_noreq%0d got %b exp 0", i, bus.imem_req_valid); end
            adv();
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL t3_xfer got %b exp 1", bus.inst_valid); end
        adv();
        bus.inst_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0100_0004) begin errors++; $display("FAIL t3_next got %b/%b/%h exp 0/1/01000004", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
    endtask

    // Test plan item 2.
    task automatic test_req_stall();
        apply_reset(32'h0000_0400);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0400 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL t2_stall%0d got %b/%h/%b exp 1/00000400/0", i, bus.imem_req_valid, bus.imem_req_addr, bus.pc_en); end
            adv();
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h0000_0404) begin errors++; $display("FAIL t2_accept got %b/%h exp 1/00000404", bus.pc_en, bus.pc_next); end
        adv();
    endtask

    // Test plan item 4.
    task automatic test_redirect_wait();
        apply_reset(32'h0100_0000);
        mem_delay = 2;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        adv();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0100_0103;
        @(negedge clk);
        checks++; if (bus.pc_en !== 1'b1 || bus.pc_next !== 32'h0100_0100) begin errors++; $display("FAIL t4_pc got %b/%h exp 1/01000100", bus.pc_en, bus.pc_next); end
        adv();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_rsp_valid !== 1'b1 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL t4_rsp got %b/%b exp 1/0", bus.imem_rsp_valid, bus.inst_valid); end
        adv();
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0100_0100) begin errors++; $display("FAIL t4_drop got %b/%b/%h exp 0/1/01000100", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
        mem_delay = 1;
        bus.imem_req_ready = 1'b1;
        adv();
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        adv();
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0100_0100 || bus.inst_data !== mem_word(32'h0100_0100)) begin errors++; $display("FAIL t4_refetch got %b/%h/%h exp 1/01000100/%h", bus.inst_valid, bus.inst_pc, bus.inst_data, mem_word(32'h0100_0100)); end
    endtask

    // Test plan item 5, plus withdraw, wrap and redirect in HOLD.
    task automatic test_redirect_fetch();
        apply_reset(32'h0200_0000);
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0300_0007;
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.pc_en !== 1'b1 || bus.pc_next !== 32'h0300_0004) begin errors++; $display("FAIL t5_acc got %b/%b/%h exp 1/1/03000004", bus.imem_req_valid, bus.pc_en, bus.pc_next); end
        adv();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        adv();
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0300_0004) begin errors++; $display("FAIL t5_drop got %b/%b/%h exp 0/1/03000004", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFE;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0 || bus.pc_en !== 1'b1 || bus.pc_next !== 32'hFFFF_FFFC) begin errors++; $display("FAIL t5_withdraw got %b/%b/%h exp 0/1/fffffffc", bus.imem_req_valid, bus.pc_en, bus.pc_next); end
        adv();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC || bus.pc_en !== 1'b1 || bus.pc_next !== 32'h0) begin errors++; $display("FAIL t5_wrap got %h/%b/%h exp fffffffc/1/00000000", bus.imem_req_addr, bus.pc_en, bus.pc_next); end
        adv();
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        adv();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0101;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFFF_FFFC || bus.pc_next !== 32'h0000_0100) begin errors++; $display("FAIL t5_hold_redir got %b/%h/%h exp 1/fffffffc/00000100", bus.inst_valid, bus.inst_pc, bus.pc_next); end
        adv();
        bus.redirect_valid = 1'b0;
        bus.inst_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0100) begin errors++; $display("FAIL t5_after got %b/%b/%h exp 0/1/00000100", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
    endtask

    // Test plan item 6.
    task automatic test_async_reset();
        apply_reset(32'h0100_0000);
        mem_delay = 2;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        adv();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0800;
        #1;
        checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL t6_wait_redir got %b exp 1", bus.pc_en); end
        rst = 1'b1;
        #1;
        checks++; if (bus.pc_en !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL t6_wait_rst got %b/%b/%b exp 0/0/0", bus.pc_en, bus.imem_req_valid, bus.inst_valid); end
        apply_reset(32'h0100_0000);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        adv();
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        adv();
        #1;
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL t6_in_hold got %b exp 1", bus.inst_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus.inst_valid !== 1'b0 || bus.inst_data !== 32'h0 || bus.imem_req_valid !== 1'b0 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL t6_hold_rst got %b/%h/%b/%b exp 0/0/0/0", bus.inst_valid, bus.inst_data, bus.imem_req_valid, bus.pc_en); end
        apply_reset(32'h0100_0000);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        adv();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL t6_stray%0d got %b/%b exp 0/1", i, bus.inst_valid, bus.imem_req_valid); end
            adv();
        end
    endtask

    // Randomized traffic checked against the ordered-stream model.
    task automatic test_random();
        logic [XLEN-1:0] base;
        base = {$urandom()} & 32'hFFFF_FFFC;
        apply_reset(base);
        mem_rand = 1'b1;
        exp_q.delete();
        exp_q.push_back(base);
        deliveries = 0;
        sb_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_req_ready  = ($urandom_range(0, 9) < 7);
            bus.inst_ready      = ($urandom_range(0, 9) < 6);
            bus.redirect_valid  = ($urandom_range(0, 19) == 0);
            bus.redirect_target = $urandom();
            @(negedge clk);
            adv();
        end
        sb_en = 1'b0;
        bus.redirect_valid = 1'b0;
        checks++; if (deliveries < 50) begin errors++; $display("FAIL rand_progress got %0d exp >=50", deliveries); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        sb_en = 1'b0;
        deliveries = 0;
        rst = 1'b1;
        pc_load = 1'b0;
        pc_load_val = '0;
        test_reset();
        test_basic_hold();
        test_req_stall();
        test_redirect_wait();
        test_redirect_fetch();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
